// File: rtl/fib_sequencer_pkg.sv
// rtl/fib_sequencer_pkg.sv - shared state encoding, widths and helpers for the Fibonacci sequencer
package fib_sequencer_pkg;

  localparam int STEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_DWELL = 3'd2,
    ST_CALC  = 3'd3,
    ST_DONE  = 3'd4
  } fib_state_t;

  // A run is in progress from the first offered value until DONE/IDLE.
  function automatic logic is_busy(input fib_state_t s);
    return (s == ST_SHOW) || (s == ST_DWELL) || (s == ST_CALC);
  endfunction

endpackage

// File: rtl/fib_sequencer_sync_edge.sv
// rtl/fib_sequencer_sync_edge.sv - two-flop synchroniser with single-cycle rising-edge pulse
module fib_sequencer_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Resynchronise the button and remember its last synchronised level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  // High for exactly one cycle per press, two edges after the input rises.
  assign rise = sync & ~prev;

endmodule

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - seeds, runs and paces a Fibonacci sequence towards the LCD value path
module fib_sequencer
  import fib_sequencer_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SW_WIDTH     = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int MAX_STEPS    = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                SetA,
  input  logic                SetB,
  input  logic                run,
  input  logic                step,
  input  logic                display_ready,
  output logic                display_valid,
  output logic [WIDTH-1:0]    display_value,
  output logic                busy,
  output logic                overflow,
  output logic [STEP_W-1:0]   step_count
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_LIMIT = STEP_W'(MAX_STEPS);

  logic seta_rise;
  logic setb_rise;
  logic run_rise;
  logic step_rise;

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [WIDTH-1:0]    sw_ext;

  fib_state_t          state, state_nxt;
  logic [WIDTH-1:0]    seed_a, seed_a_nxt;
  logic [WIDTH-1:0]    seed_b, seed_b_nxt;
  logic [WIDTH-1:0]    a_reg, a_nxt;
  logic [WIDTH-1:0]    b_reg, b_nxt;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
  logic                valid_nxt;
  logic [WIDTH-1:0]    value_nxt;
  logic                overflow_nxt;
  logic [STEP_W-1:0]   step_count_nxt;
  logic [WIDTH:0]      sum;

  fib_sequencer_sync_edge u_sync_seta (.clk(clk), .reset(reset), .async_in(SetA), .rise(seta_rise));
  fib_sequencer_sync_edge u_sync_setb (.clk(clk), .reset(reset), .async_in(SetB), .rise(setb_rise));
  fib_sequencer_sync_edge u_sync_run  (.clk(clk), .reset(reset), .async_in(run),  .rise(run_rise));
  fib_sequencer_sync_edge u_sync_step (.clk(clk), .reset(reset), .async_in(step), .rise(step_rise));

  // Bring the seed switches into the clock domain; they are sampled only on a Set press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  assign sw_ext = WIDTH'(sw_sync);
  assign sum    = {1'b0, a_reg} + {1'b0, b_reg};
  assign busy   = is_busy(state);

  // Next-state and datapath decisions; every register holds unless a branch says otherwise.
  always_comb begin
    state_nxt      = state;
    seed_a_nxt     = seed_a;
    seed_b_nxt     = seed_b;
    a_nxt          = a_reg;
    b_nxt          = b_reg;
    dwell_nxt      = dwell_cnt;
    valid_nxt      = display_valid;
    value_nxt      = display_value;
    overflow_nxt   = overflow;
    step_count_nxt = step_count;

    if (is_busy(state) && run_rise) begin
      // Abort: drop the offer, keep the count and the last shown value.
      state_nxt = ST_IDLE;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_rise) begin
            a_nxt          = seed_a;
            b_nxt          = seed_b;
            step_count_nxt = '0;
            overflow_nxt   = 1'b0;
            value_nxt      = seed_a;
            valid_nxt      = 1'b1;
            state_nxt      = ST_SHOW;
          end else if (seta_rise || setb_rise) begin
            if (seta_rise) seed_a_nxt = sw_ext;
            if (setb_rise) seed_b_nxt = sw_ext;
            value_nxt = sw_ext;
            state_nxt = ST_IDLE;
          end
        end
        ST_SHOW: begin
          if (display_valid && display_ready) begin
            valid_nxt      = 1'b0;
            step_count_nxt = step_count + 1'b1;
            dwell_nxt      = DWELL_LOAD;
            state_nxt      = ST_DWELL;
          end
        end
        ST_DWELL: begin
          if ((dwell_cnt == '0) || step_rise) begin
            state_nxt = (step_count == STEP_LIMIT) ? ST_DONE : ST_CALC;
          end else begin
            dwell_nxt = dwell_cnt - 1'b1;
          end
        end
        ST_CALC: begin
          if (step_count == STEP_W'(1)) begin
            // Second value is the B seed itself; no addition yet.
            value_nxt = b_reg;
            valid_nxt = 1'b1;
            state_nxt = ST_SHOW;
          end else if (sum[WIDTH]) begin
            overflow_nxt = 1'b1;
            state_nxt    = ST_DONE;
          end else begin
            a_nxt     = b_reg;
            b_nxt     = sum[WIDTH-1:0];
            value_nxt = sum[WIDTH-1:0];
            valid_nxt = 1'b1;
            state_nxt = ST_SHOW;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Register the controller state, the seeds, the working pair and the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      seed_a        <= '0;
      seed_b        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      dwell_cnt     <= '0;
      display_valid <= 1'b0;
      display_value <= '0;
      overflow      <= 1'b0;
      step_count    <= '0;
    end else begin
      state         <= state_nxt;
      seed_a        <= seed_a_nxt;
      seed_b        <= seed_b_nxt;
      a_reg         <= a_nxt;
      b_reg         <= b_nxt;
      dwell_cnt     <= dwell_nxt;
      display_valid <= valid_nxt;
      display_value <= value_nxt;
      overflow      <= overflow_nxt;
      step_count    <= step_count_nxt;
    end
  end

endmodule
